// File: rtl/cond_ctrl_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cond_pkg : condition codes, NZCV bit indices and control bundle layouts
// Rev 1.0
// ----------------------------------------------------------------------------
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       pcsrc;
    logic       alusrc;
    logic       mc;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic pcsrc;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } wb_ctrl_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

endpackage
`default_nettype wire

// File: rtl/cond_ctrl_pipe_cond_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cond_unit : combinational ARM condition-field evaluator against NZCV
// Rev 1.0
// ----------------------------------------------------------------------------
module cond_unit
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = ~(n ^ v);
      COND_LT: condex = n ^ v;
      COND_GT: condex = ~z & ~(n ^ v);
      COND_LE: condex = z | (n ^ v);
      COND_AL: condex = 1'b1;
      COND_NV: condex = 1'b0;
      default: condex = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_ctrl_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cond_ctrl_pipe : D->E->M->W control pipe with condition gating and MC hold
// Rev 1.0
// ----------------------------------------------------------------------------
module cond_ctrl_pipe
  import cond_pkg::*;
#(
  parameter int ALUCTRL_W = 5,
  parameter int SIDE_W    = 4,
  parameter int MC_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_d,
  input  logic [3:0]           cond_d,
  input  logic                 regwrite_d,
  input  logic                 memwrite_d,
  input  logic                 memtoreg_d,
  input  logic                 branch_d,
  input  logic                 pcsrc_d,
  input  logic                 alusrc_d,
  input  logic                 mc_d,
  input  logic [1:0]           flagwrite_d,
  input  logic [ALUCTRL_W-1:0] aluctrl_d,
  input  logic [SIDE_W-1:0]    side_d,
  input  logic                 stall_d,
  input  logic                 flush_e,
  input  logic [3:0]           alu_flags_e,
  output logic                 alusrc_e,
  output logic [ALUCTRL_W-1:0] aluctrl_e,
  output logic                 carry_e,
  output logic                 memtoreg_e,
  output logic                 branch_taken_e,
  output logic                 regwrite_m,
  output logic                 memwrite_m,
  output logic                 memtoreg_m,
  output logic                 regwrite_w,
  output logic                 memtoreg_w,
  output logic                 pcsrc_w,
  output logic [SIDE_W-1:0]    side_w,
  output logic [3:0]           flags_q,
  output logic                 mc_busy,
  output logic                 pc_wr_pending_f
);

  ctrl_t                ex_q, ex_d;
  logic [ALUCTRL_W-1:0] ex_alu_q, ex_alu_d;
  logic [SIDE_W-1:0]    ex_side_q, ex_side_d;
  mem_ctrl_t            mem_q, mem_d;
  logic [SIDE_W-1:0]    mem_side_q, mem_side_d;
  wb_ctrl_t             wb_q, wb_d;
  logic [SIDE_W-1:0]    wb_side_q, wb_side_d;
  mc_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           flags_d;
  logic                 condex;
  logic [1:0]           flagwrite_g;

  cond_unit u_cond_unit (
    .cond   (ex_q.cond),
    .flags  (flags_q),
    .condex (condex)
  );

  // mc_busy covers the launch cycle too, so E holds for MC_LAT cycles in total
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_q.mc && condex) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(MC_LAT - 2);
          mc_busy = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          mc_busy = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flagwrite_g = ex_q.flagwrite & {2{condex}};

  always_comb begin
    ex_d      = ex_q;
    ex_alu_d  = ex_alu_q;
    ex_side_d = ex_side_q;
    if (!mc_busy) begin
      ex_d      = '0;
      ex_alu_d  = '0;
      ex_side_d = '0;
      if (valid_d && !stall_d && !flush_e) begin
        ex_d.regwrite  = regwrite_d;
        ex_d.memwrite  = memwrite_d;
        ex_d.memtoreg  = memtoreg_d;
        ex_d.branch    = branch_d;
        ex_d.pcsrc     = pcsrc_d;
        ex_d.alusrc    = alusrc_d;
        ex_d.mc        = mc_d;
        ex_d.flagwrite = flagwrite_d;
        ex_d.cond      = cond_d;
        ex_alu_d       = aluctrl_d;
        ex_side_d      = side_d;
      end
    end
  end

  always_comb begin
    mem_d      = '0;
    mem_side_d = '0;
    flags_d    = flags_q;
    if (!mc_busy) begin
      mem_d.regwrite = ex_q.regwrite & condex;
      mem_d.memwrite = ex_q.memwrite & condex;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.pcsrc    = ex_q.pcsrc & condex;
      mem_side_d     = ex_side_q;
      if (flagwrite_g[1]) begin
        flags_d[FLAG_N] = alu_flags_e[FLAG_N];
        flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
      end
      if (flagwrite_g[0]) begin
        flags_d[FLAG_C] = alu_flags_e[FLAG_C];
        flags_d[FLAG_V] = alu_flags_e[FLAG_V];
      end
    end
    wb_d.regwrite = mem_q.regwrite;
    wb_d.memtoreg = mem_q.memtoreg;
    wb_d.pcsrc    = mem_q.pcsrc;
    wb_side_d     = mem_side_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_alu_q   <= '0;
      ex_side_q  <= '0;
      mem_q      <= '0;
      mem_side_q <= '0;
      wb_q       <= '0;
      wb_side_q  <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flags_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_alu_q   <= ex_alu_d;
      ex_side_q  <= ex_side_d;
      mem_q      <= mem_d;
      mem_side_q <= mem_side_d;
      wb_q       <= wb_d;
      wb_side_q  <= wb_side_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
    end
  end

  assign alusrc_e        = ex_q.alusrc;
  assign aluctrl_e       = ex_alu_q;
  assign carry_e         = flags_q[FLAG_C];
  assign memtoreg_e      = ex_q.memtoreg;
  assign branch_taken_e  = ex_q.branch & condex;
  assign regwrite_m      = mem_q.regwrite;
  assign memwrite_m      = mem_q.memwrite;
  assign memtoreg_m      = mem_q.memtoreg;
  assign regwrite_w      = wb_q.regwrite;
  assign memtoreg_w      = wb_q.memtoreg;
  assign pcsrc_w         = wb_q.pcsrc;
  assign side_w          = wb_side_q;
  assign pc_wr_pending_f = (pcsrc_d & valid_d) | ex_q.pcsrc | mem_q.pcsrc;

endmodule
`default_nettype wire

// File: tb/tb_cond_ctrl_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cond_ctrl_pipe : directed + random stimulus against a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cond_ctrl_pipe;

  localparam int ALUCTRL_W = 5;
  localparam int SIDE_W    = 4;
  localparam int MC_LAT    = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 valid_d = 1'b0;
  logic [3:0]           cond_d = '0;
  logic                 regwrite_d = 1'b0, memwrite_d = 1'b0, memtoreg_d = 1'b0;
  logic                 branch_d = 1'b0, pcsrc_d = 1'b0, alusrc_d = 1'b0, mc_d = 1'b0;
  logic [1:0]           flagwrite_d = '0;
  logic [ALUCTRL_W-1:0] aluctrl_d = '0;
  logic [SIDE_W-1:0]    side_d = '0;
  logic                 stall_d = 1'b0, flush_e = 1'b0;
  logic [3:0]           alu_flags_e = '0;
  logic                 alusrc_e, carry_e, memtoreg_e, branch_taken_e;
  logic [ALUCTRL_W-1:0] aluctrl_e;
  logic                 regwrite_m, memwrite_m, memtoreg_m;
  logic                 regwrite_w, memtoreg_w, pcsrc_w;
  logic [SIDE_W-1:0]    side_w;
  logic [3:0]           flags_q;
  logic                 mc_busy, pc_wr_pending_f;

  always #5 clk = ~clk;

  cond_ctrl_pipe #(
    .ALUCTRL_W (ALUCTRL_W),
    .SIDE_W    (SIDE_W),
    .MC_LAT    (MC_LAT)
  ) dut (
    .clk (clk), .reset (reset), .valid_d (valid_d), .cond_d (cond_d),
    .regwrite_d (regwrite_d), .memwrite_d (memwrite_d), .memtoreg_d (memtoreg_d),
    .branch_d (branch_d), .pcsrc_d (pcsrc_d), .alusrc_d (alusrc_d), .mc_d (mc_d),
    .flagwrite_d (flagwrite_d), .aluctrl_d (aluctrl_d), .side_d (side_d),
    .stall_d (stall_d), .flush_e (flush_e), .alu_flags_e (alu_flags_e),
    .alusrc_e (alusrc_e), .aluctrl_e (aluctrl_e), .carry_e (carry_e),
    .memtoreg_e (memtoreg_e), .branch_taken_e (branch_taken_e),
    .regwrite_m (regwrite_m), .memwrite_m (memwrite_m), .memtoreg_m (memtoreg_m),
    .regwrite_w (regwrite_w), .memtoreg_w (memtoreg_w), .pcsrc_w (pcsrc_w),
    .side_w (side_w), .flags_q (flags_q), .mc_busy (mc_busy),
    .pc_wr_pending_f (pc_wr_pending_f)
  );

  typedef struct packed {
    logic                 rw, mw, mtr, br, pcs, asrc, mc;
    logic [1:0]           fw;
    logic [3:0]           cond;
    logic [ALUCTRL_W-1:0] alu;
    logic [SIDE_W-1:0]    side;
  } op_t;

  // Reference model: the op sitting in E, how long it has been there, and
  // what has moved on to M and W.
  op_t        m_e, m_m, m_w;
  logic [3:0] m_flags;
  int         m_age;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  // Odd codes negate the even code below them, except 4'b1111 (never).
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b0;
    return cond[0] ? !base : base;
  endfunction

  function automatic op_t d_op();
    op_t o;
    o.rw = regwrite_d; o.mw = memwrite_d; o.mtr = memtoreg_d; o.br = branch_d;
    o.pcs = pcsrc_d; o.asrc = alusrc_d; o.mc = mc_d; o.fw = flagwrite_d;
    o.cond = cond_d; o.alu = aluctrl_d; o.side = side_d;
    return o;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic cx, busy;
    @(negedge clk);
    cx   = cond_true(m_e.cond, m_flags);
    busy = m_e.mc && cx && (m_age < MC_LAT - 1);
    check_val("flags_q",         32'(flags_q),         32'(m_flags));
    check_val("mc_busy",         32'(mc_busy),         32'(busy));
    check_val("alusrc_e",        32'(alusrc_e),        32'(m_e.asrc));
    check_val("aluctrl_e",       32'(aluctrl_e),       32'(m_e.alu));
    check_val("carry_e",         32'(carry_e),         32'(m_flags[1]));
    check_val("memtoreg_e",      32'(memtoreg_e),      32'(m_e.mtr));
    check_val("branch_taken_e",  32'(branch_taken_e),  32'(m_e.br && cx));
    check_val("regwrite_m",      32'(regwrite_m),      32'(m_m.rw));
    check_val("memwrite_m",      32'(memwrite_m),      32'(m_m.mw));
    check_val("memtoreg_m",      32'(memtoreg_m),      32'(m_m.mtr));
    check_val("regwrite_w",      32'(regwrite_w),      32'(m_w.rw));
    check_val("memtoreg_w",      32'(memtoreg_w),      32'(m_w.mtr));
    check_val("pcsrc_w",         32'(pcsrc_w),         32'(m_w.pcs));
    check_val("side_w",          32'(side_w),          32'(m_w.side));
    check_val("pc_wr_pending_f", 32'(pc_wr_pending_f),
              32'((pcsrc_d && valid_d) || m_e.pcs || m_m.pcs));
    if (reset) begin
      m_e = '0; m_m = '0; m_w = '0; m_flags = '0; m_age = 0;
    end else begin
      m_w = m_m;
      if (!busy) begin
        m_m      = '0;
        m_m.rw   = m_e.rw && cx;
        m_m.mw   = m_e.mw && cx;
        m_m.mtr  = m_e.mtr;
        m_m.pcs  = m_e.pcs && cx;
        m_m.side = m_e.side;
        if (m_e.fw[1] && cx) m_flags[3:2] = alu_flags_e[3:2];
        if (m_e.fw[0] && cx) m_flags[1:0] = alu_flags_e[1:0];
        m_e   = (valid_d && !stall_d && !flush_e) ? d_op() : '0;
        m_age = 0;
      end else begin
        m_m = '0;
        m_age++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_d(input logic v, input logic [3:0] cond, input logic rw, input logic mw,
                       input logic mtr, input logic br, input logic pcs, input logic mc,
                       input logic [1:0] fw);
    valid_d = v; cond_d = cond; regwrite_d = rw; memwrite_d = mw; memtoreg_d = mtr;
    branch_d = br; pcsrc_d = pcs; mc_d = mc; flagwrite_d = fw;
    alusrc_d  = v ? 1'($urandom_range(0, 1)) : 1'b0;
    aluctrl_d = v ? ALUCTRL_W'($urandom_range(1, (1 << ALUCTRL_W) - 1)) : '0;
    side_d    = v ? SIDE_W'($urandom_range(1, (1 << SIDE_W) - 1)) : '0;
    stall_d = 1'b0; flush_e = 1'b0;
  endtask

  task automatic bubble();
    set_d(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic rand_inputs();
    valid_d     = ($urandom_range(0, 9) < 8);
    cond_d      = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    regwrite_d  = 1'($urandom_range(0, 1));
    memwrite_d  = 1'($urandom_range(0, 1));
    memtoreg_d  = 1'($urandom_range(0, 1));
    branch_d    = ($urandom_range(0, 5) == 0);
    pcsrc_d     = ($urandom_range(0, 5) == 0);
    alusrc_d    = 1'($urandom_range(0, 1));
    mc_d        = ($urandom_range(0, 6) == 0);
    flagwrite_d = 2'($urandom_range(0, 3));
    aluctrl_d   = ALUCTRL_W'($urandom);
    side_d      = SIDE_W'($urandom);
    stall_d     = ($urandom_range(0, 9) == 0);
    flush_e     = ($urandom_range(0, 9) == 0);
    alu_flags_e = 4'($urandom);
    reset       = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    m_e = '0; m_m = '0; m_w = '0; m_flags = '0; m_age = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // ADD AL with full flag write
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    alu_flags_e = 4'b0100;
    step();
    bubble();
    repeat (4) step();

    // NE while Z=1 -> annulled
    set_d(1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    alu_flags_e = 4'b1011;
    step();
    bubble();
    repeat (3) step();

    // MUL followed by an ADD held in D until E frees up
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (MC_LAT) step();
    bubble();
    repeat (4) step();

    // Taken branch, then flush+stall together
    set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    step();
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    flush_e = 1'b1;
    stall_d = 1'b1;
    step();
    bubble();
    repeat (3) step();

    // Reset during a multi-cycle hold
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    alu_flags_e = 4'b1111;
    step();
    bubble();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();

    // Multi-cycle op with EQ while Z=0 -> annulled single cycle
    set_d(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    bubble();
    repeat (3) step();

    repeat (800) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
